// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between the instruction cache
// (line reads) and the data cache (line reads and line writebacks).
// One transaction at a time. Base priority is D write > D read > I read, and
// an instruction fetch that has waited through STARVE_LIMIT data grants is
// forced through ahead of everything.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : a busy-state watchdog aborts a transaction whose completion
//               has not arrived after TIMEOUT_CYCLES busy cycles. The owner
//               receives its completion pulse (read data 0) and memError
//               pulses for one cycle.
//   undefined : busy states wait indefinitely; memError is tied 0.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   iReadReq/Addr    icache line-read request, held until iDataValid
//   iData/iDataValid icache return line and one-cycle completion pulse
//   dReadReq/Addr    dcache line-read request, held until dDataValid
//   dData/dDataValid dcache return line and one-cycle completion pulse
//   dWriteReq/Addr/Data  dcache writeback request, held until dWriteDone
//   dWriteDone       one-cycle writeback completion pulse
//   memReadReq       read strobe, high for the whole read
//   memReadAddr      latched read address
//   memWriteAddr     latched write address
//   memWriteData     latched write line
//   memWriteEn       write enable, high for the whole write
//   memData          memory read data
//   memDataValid     memory read completion
//   memWriteDone     memory write completion
//   memError         one-cycle timeout pulse
//
// Completion pulses and return data are combinational from the memory
// completion inputs so the requester sees them in the same cycle.

module mem_arbiter #(
   parameter int unsigned ARCH_BITS        = 32,
   parameter int unsigned MEMORY_LINE_BITS = 128,
   parameter int unsigned STARVE_LIMIT     = 4,
   parameter int unsigned TIMEOUT_CYCLES   = 64
) (
   input  logic                        clk,
   input  logic                        rst,

   input  logic                        iReadReq,
   input  logic [ARCH_BITS-1:0]        iReadAddr,
   output logic [MEMORY_LINE_BITS-1:0] iData,
   output logic                        iDataValid,

   input  logic                        dReadReq,
   input  logic [ARCH_BITS-1:0]        dReadAddr,
   output logic [MEMORY_LINE_BITS-1:0] dData,
   output logic                        dDataValid,

   input  logic                        dWriteReq,
   input  logic [ARCH_BITS-1:0]        dWriteAddr,
   input  logic [MEMORY_LINE_BITS-1:0] dWriteData,
   output logic                        dWriteDone,

   output logic                        memReadReq,
   output logic [ARCH_BITS-1:0]        memReadAddr,
   output logic [ARCH_BITS-1:0]        memWriteAddr,
   output logic [MEMORY_LINE_BITS-1:0] memWriteData,
   output logic                        memWriteEn,
   input  logic [MEMORY_LINE_BITS-1:0] memData,
   input  logic                        memDataValid,
   input  logic                        memWriteDone,
   output logic                        memError
);

   // STARVE_LIMIT is at most 255, so eight bits always hold the counter.
   localparam int unsigned STARVE_BITS = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IREAD  = 2'd1,
      DREAD  = 2'd2,
      DWRITE = 2'd3
   } arbState_t;

   arbState_t               state;
   arbState_t               nextState;
   logic [STARVE_BITS-1:0]  starveCnt;
   logic                    starved;
   logic                    grant;
   logic                    realDone;
   logic                    timeoutHit;
   logic                    finish;

   // Instruction fetch has waited through enough data grants to be forced.
   assign starved = iReadReq && (starveCnt == STARVE_BITS'(STARVE_LIMIT));

   // Memory completion that belongs to the current owner; anything else is ignored.
   always_comb begin
      realDone = 1'b0;
      case (state)
         IREAD, DREAD: realDone = memDataValid;
         DWRITE:       realDone = memWriteDone;
         default:      realDone = 1'b0;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned BUSY_BITS = $clog2(TIMEOUT_CYCLES + 1);

   logic [BUSY_BITS-1:0] busyCnt;

   // Busy cycle counter: zero in the first busy cycle, counts up while busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busyCnt <= '0;
      end else if (state == IDLE) begin
         busyCnt <= '0;
      end else begin
         busyCnt <= busyCnt + BUSY_BITS'(1);
      end
   end

   // Watchdog fires on the last budgeted cycle unless the real completion arrives then.
   assign timeoutHit = (state != IDLE) && !realDone &&
                       (busyCnt == BUSY_BITS'(TIMEOUT_CYCLES - 1));
`else
   logic unusedTimeout;
   assign unusedTimeout = ^TIMEOUT_CYCLES;
   assign timeoutHit    = 1'b0;
`endif

   assign finish = realDone || timeoutHit;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state: priority select in IDLE, return to IDLE on completion.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (starved) begin
               nextState = IREAD;
            end else if (dWriteReq) begin
               nextState = DWRITE;
            end else if (dReadReq) begin
               nextState = DREAD;
            end else if (iReadReq) begin
               nextState = IREAD;
            end
         end
         IREAD, DREAD, DWRITE: begin
            if (finish) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Outputs: strobes follow the state, completions follow the memory inputs.
   always_comb begin
      memReadReq = 1'b0;
      memWriteEn = 1'b0;
      iDataValid = 1'b0;
      iData      = '0;
      dDataValid = 1'b0;
      dData      = '0;
      dWriteDone = 1'b0;
      memError   = timeoutHit;
      case (state)
         IREAD: begin
            memReadReq = 1'b1;
            iDataValid = finish;
            if (memDataValid) begin
               iData = memData;
            end
         end
         DREAD: begin
            memReadReq = 1'b1;
            dDataValid = finish;
            if (memDataValid) begin
               dData = memData;
            end
         end
         DWRITE: begin
            memWriteEn = 1'b1;
            dWriteDone = finish;
         end
         default: ;
      endcase
   end

   assign grant = (state == IDLE) && (nextState != IDLE);

   // Grant-time capture of the winner's address/data and starvation bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         memReadAddr  <= '0;
         memWriteAddr <= '0;
         memWriteData <= '0;
         starveCnt    <= '0;
      end else if (grant) begin
         case (nextState)
            IREAD: begin
               memReadAddr <= iReadAddr;
               starveCnt   <= '0;
            end
            DREAD: begin
               memReadAddr <= dReadAddr;
               if (iReadReq && (starveCnt != STARVE_BITS'(STARVE_LIMIT))) begin
                  starveCnt <= starveCnt + STARVE_BITS'(1);
               end
            end
            DWRITE: begin
               memWriteAddr <= dWriteAddr;
               memWriteData <= dWriteData;
               if (iReadReq && (starveCnt != STARVE_BITS'(STARVE_LIMIT))) begin
                  starveCnt <= starveCnt + STARVE_BITS'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transactions against a cycle-level
// owner/queue model of the arbitration rules, plus literal expectations.
module tb_mem_arbiter;

   localparam int unsigned AB = 32;
   localparam int unsigned LB = 128;
   localparam int SL = 4;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          iReadReq = 1'b0;
   logic [AB-1:0] iReadAddr = '0;
   logic [LB-1:0] iData;
   logic          iDataValid;
   logic          dReadReq = 1'b0;
   logic [AB-1:0] dReadAddr = '0;
   logic [LB-1:0] dData;
   logic          dDataValid;
   logic          dWriteReq = 1'b0;
   logic [AB-1:0] dWriteAddr = '0;
   logic [LB-1:0] dWriteData = '0;
   logic          dWriteDone;
   logic          memReadReq;
   logic [AB-1:0] memReadAddr;
   logic [AB-1:0] memWriteAddr;
   logic [LB-1:0] memWriteData;
   logic          memWriteEn;
   logic [LB-1:0] memData = '0;
   logic          memDataValid = 1'b0;
   logic          memWriteDone = 1'b0;
   logic          memError;

   mem_arbiter #(.ARCH_BITS(AB), .MEMORY_LINE_BITS(LB), .STARVE_LIMIT(SL),
                 .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .iReadReq(iReadReq), .iReadAddr(iReadAddr), .iData(iData), .iDataValid(iDataValid),
      .dReadReq(dReadReq), .dReadAddr(dReadAddr), .dData(dData), .dDataValid(dDataValid),
      .dWriteReq(dWriteReq), .dWriteAddr(dWriteAddr), .dWriteData(dWriteData),
      .dWriteDone(dWriteDone),
      .memReadReq(memReadReq), .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr),
      .memWriteData(memWriteData), .memWriteEn(memWriteEn), .memData(memData),
      .memDataValid(memDataValid), .memWriteDone(memWriteDone), .memError(memError));

   always #5 clk = ~clk;

   // Memory: answers after a fixed number of strobe cycles (0 = never), plus injected pulses.
   int            rdLat = 5, wrLat = 3, rdCnt = 0, wrCnt = 0;
   logic [LB-1:0] rdLine = '0;
   bit            memRandom = 1'b1, injRd = 1'b0, injWr = 1'b0;

   always @(posedge clk) begin
      #2;
      if (memRandom) begin
         memData      = {$urandom, $urandom, $urandom, $urandom};
         memDataValid = 1'($urandom_range(1));
         memWriteDone = 1'($urandom_range(1));
      end else begin
         rdCnt = memReadReq ? rdCnt + 1 : 0;
         wrCnt = memWriteEn ? wrCnt + 1 : 0;
         memData      = rdLine;
         memDataValid = injRd || (memReadReq && rdLat != 0 && rdCnt == rdLat);
         memWriteDone = injWr || (memWriteEn && wrLat != 0 && wrCnt == wrLat);
      end
   end

   // Model: owner 0=none 1=I 2=D read 3=D write; grants logged for literal checks.
   int            mOwner = 0, mStarve = 0, mBusy = 0, cyc = 0;
   logic [AB-1:0] mRdAddr = '0, mWrAddr = '0;
   logic [LB-1:0] mWrData = '0;
   int            logOwner[$];
   int            logCycle[$];
   logic [AB-1:0] logAddr[$];

   function automatic bit mReal();
      if (mOwner == 1 || mOwner == 2) return memDataValid;
      if (mOwner == 3) return memWriteDone;
      return 1'b0;
   endfunction

   function automatic bit mTimeout();
`ifdef MEM_TIMEOUT_EN
      return (mOwner != 0) && !mReal() && (mBusy == TO - 1);
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk or negedge rst) begin
      int win;
      if (!rst) begin
         mOwner = 0; mStarve = 0; mBusy = 0;
         mRdAddr = '0; mWrAddr = '0; mWrData = '0;
      end else begin
         cyc++;
         if (mOwner == 0) begin
            win = 0;
            if (iReadReq && mStarve == SL) win = 1;
            else if (dWriteReq)            win = 3;
            else if (dReadReq)             win = 2;
            else if (iReadReq)             win = 1;
            if (win == 1) begin
               mStarve = 0;
               mRdAddr = iReadAddr;
            end else if (win != 0) begin
               if (iReadReq) mStarve = (mStarve < SL) ? mStarve + 1 : SL;
               if (win == 2) mRdAddr = dReadAddr;
               else begin mWrAddr = dWriteAddr; mWrData = dWriteData; end
            end
            if (win != 0) begin
               logOwner.push_back(win);
               logCycle.push_back(cyc);
               logAddr.push_back(win == 1 ? iReadAddr : (win == 2 ? dReadAddr : dWriteAddr));
               mOwner = win;
               mBusy  = 0;
            end
         end else if (mReal() || mTimeout()) begin
            mOwner = 0;
         end else begin
            mBusy++;
         end
      end
   end

   // Requester queues and observation counters (all owned by the stimulus process).
   logic [AB-1:0] qI[$], qR[$], qWA[$];
   logic [LB-1:0] qWD[$];
   int            errors = 0, checks = 0;
   int            iDone = 0, rDone = 0, wDone = 0, errCnt = 0, rdHigh = 0;
   logic [LB-1:0] lastIData = '0, lastDData = '0;

   task automatic chkV(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chkB(input string name, input logic act, input logic exp);
      chkV(name, LB'(act), LB'(exp));
   endtask

   task automatic chkI(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      bit r, t;
      r = mReal();
      t = mTimeout();
      chkB("iDataValid", iDataValid, (mOwner == 1) && (r || t));
      chkV("iData", iData, (mOwner == 1 && memDataValid) ? memData : '0);
      chkB("dDataValid", dDataValid, (mOwner == 2) && (r || t));
      chkV("dData", dData, (mOwner == 2 && memDataValid) ? memData : '0);
      chkB("dWriteDone", dWriteDone, (mOwner == 3) && (r || t));
      chkB("memReadReq", memReadReq, mOwner == 1 || mOwner == 2);
      chkB("memWriteEn", memWriteEn, mOwner == 3);
      chkV("memReadAddr", LB'(memReadAddr), LB'(mRdAddr));
      chkV("memWriteAddr", LB'(memWriteAddr), LB'(mWrAddr));
      chkV("memWriteData", memWriteData, mWrData);
      chkB("memError", memError, t);
      if (memReadReq) rdHigh++;
      if (memError) errCnt++;
      if (iDataValid) begin
         iDone++; lastIData = iData;
         if (qI.size() != 0) void'(qI.pop_front());
      end
      if (dDataValid) begin
         rDone++; lastDData = dData;
         if (qR.size() != 0) void'(qR.pop_front());
      end
      if (dWriteDone) begin
         wDone++;
         if (qWA.size() != 0) begin void'(qWA.pop_front()); void'(qWD.pop_front()); end
      end
   endtask

   // One clock: requesters drive at +1, memory at +2, compare on the falling edge.
   task automatic tick(input bit drive);
      @(posedge clk);
      #1;
      if (drive) begin
         if (!rst) begin qI.delete(); qR.delete(); qWA.delete(); qWD.delete(); end
         iReadReq   = (qI.size() != 0);
         iReadAddr  = (qI.size() != 0) ? qI[0] : '0;
         dReadReq   = (qR.size() != 0);
         dReadAddr  = (qR.size() != 0) ? qR[0] : '0;
         dWriteReq  = (qWA.size() != 0);
         dWriteAddr = (qWA.size() != 0) ? qWA[0] : '0;
         dWriteData = (qWD.size() != 0) ? qWD[0] : '0;
      end
      @(negedge clk);
      compare();
   endtask

   task automatic runQuiet(input string name, input int budget);
      int n;
      bit quiet;
      n = 0;
      quiet = 1'b0;
      while (!quiet && n < budget) begin
         tick(1'b1);
         n++;
         quiet = (qI.size() == 0) && (qR.size() == 0) && (qWA.size() == 0) && (mOwner == 0);
      end
      checks++;
      if (!quiet) begin
         errors++;
         $display("FAIL %s: not idle after %0d cycles", name, budget);
      end
   endtask

   initial begin
      int b, i0, r0, w0, e0, h0;
      int expOwn[7];

      // Reset held with random inputs: every output must be 0.
      for (int k = 0; k < 5; k++) begin
         tick(1'b0);
         iReadReq = 1'($urandom_range(1)); dReadReq = 1'($urandom_range(1));
         dWriteReq = 1'($urandom_range(1));
         iReadAddr = $urandom; dReadAddr = $urandom; dWriteAddr = $urandom;
         dWriteData = {$urandom, $urandom, $urandom, $urandom};
      end
      chkB("rst_memReadReq", memReadReq, 1'b0);
      chkB("rst_memWriteEn", memWriteEn, 1'b0);
      chkV("rst_memReadAddr", LB'(memReadAddr), '0);
      chkV("rst_memWriteData", memWriteData, '0);
      iReadReq = 1'b0; dReadReq = 1'b0; dWriteReq = 1'b0;
      memRandom = 1'b0;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) tick(1'b1);
      chkB("idle_memReadReq", memReadReq, 1'b0);
      chkI("idle_grants", logOwner.size(), 0);

      // I read alone.
      b = logOwner.size(); i0 = iDone; h0 = rdHigh;
      rdLat = 5; rdLine = {4{32'hA5A5_A5A5}};
      qI.push_back(32'h1000);
      runQuiet("t1_quiet", 30);
      chkI("t1_grants", logOwner.size() - b, 1);
      chkI("t1_owner", logOwner[b], 1);
      chkV("t1_memReadAddr", LB'(memReadAddr), LB'(32'h1000));
      chkI("t1_strobeCycles", rdHigh - h0, 5);
      chkI("t1_iDone", iDone - i0, 1);
      chkV("t1_iData", lastIData, {4{32'hA5A5_A5A5}});

      // Simultaneous requests: write, then D read, then I read.
      b = logOwner.size(); w0 = wDone;
      rdLat = 2; wrLat = 3; rdLine = {4{32'hCAFE_0123}};
      qWA.push_back(32'h2000); qWD.push_back({16{8'h11}});
      qR.push_back(32'h3000);
      qI.push_back(32'h1000);
      runQuiet("t2_quiet", 40);
      chkI("t2_grants", logOwner.size() - b, 3);
      chkI("t2_own0", logOwner[b], 3);
      chkI("t2_own1", logOwner[b+1], 2);
      chkI("t2_own2", logOwner[b+2], 1);
      chkV("t2_addr0", LB'(logAddr[b]), LB'(32'h2000));
      chkV("t2_addr1", LB'(logAddr[b+1]), LB'(32'h3000));
      chkV("t2_addr2", LB'(logAddr[b+2]), LB'(32'h1000));
      chkI("t2_gap01", logCycle[b+1] - logCycle[b], 4);
      chkI("t2_gap12", logCycle[b+2] - logCycle[b+1], 3);
      chkV("t2_memWriteData", memWriteData, {16{8'h11}});
      chkI("t2_wDone", wDone - w0, 1);

      // Starvation: continuous D reads with a pending I read.
      b = logOwner.size();
      for (int k = 0; k < 6; k++) qR.push_back(32'h4000 + 32'(k * 16));
      qI.push_back(32'h5000);
      runQuiet("t3_quiet", 60);
      expOwn = '{2, 2, 2, 2, 1, 2, 2};
      chkI("t3_grants", logOwner.size() - b, 7);
      for (int k = 0; k < 7; k++) chkI($sformatf("t3_own%0d", k), logOwner[b+k], expOwn[k]);
      chkV("t3_iAddr", LB'(logAddr[b+4]), LB'(32'h5000));
      chkI("t3_starve", mStarve, 0);
      chkV("t3_lastAddr", LB'(memReadAddr), LB'(32'h4050));

      // Stray completions in IDLE produce nothing.
      b = logOwner.size(); i0 = iDone; r0 = rDone; w0 = wDone; e0 = errCnt;
      injRd = 1'b1; injWr = 1'b1;
      tick(1'b1);
      injRd = 1'b0; injWr = 1'b0;
      for (int k = 0; k < 3; k++) tick(1'b1);
      chkI("t4_pulses", (iDone - i0) + (rDone - r0) + (wDone - w0), 0);
      chkI("t4_grants", logOwner.size() - b, 0);
      chkI("t4_err", errCnt - e0, 0);

      // Reset two cycles into a write; late completion afterwards is ignored.
      w0 = wDone; wrLat = 0;
      qWA.push_back(32'h6000); qWD.push_back({4{32'hDEAD_BEEF}});
      for (int k = 0; k < 10 && !memWriteEn; k++) tick(1'b1);
      chkB("t5_writing", memWriteEn, 1'b1);
      tick(1'b1);
      rst = 1'b0;
      #1;
      chkB("t5_memWriteEn_drop", memWriteEn, 1'b0);
      chkV("t5_memWriteAddr_clr", LB'(memWriteAddr), '0);
      tick(1'b1); tick(1'b1);
      rst = 1'b1;
      b = logOwner.size();
      tick(1'b1);
      injWr = 1'b1;
      tick(1'b1);
      injWr = 1'b0;
      for (int k = 0; k < 3; k++) tick(1'b1);
      chkI("t5_noDone", wDone - w0, 0);
      chkI("t5_noGrant", logOwner.size() - b, 0);

`ifdef MEM_TIMEOUT_EN
      // Memory never answers a D read: watchdog completes it with data 0.
      r0 = rDone; e0 = errCnt; h0 = rdHigh; rdLat = 0;
      qR.push_back(32'h7000);
      runQuiet("t6_quiet", 40);
      chkI("t6_strobeCycles", rdHigh - h0, TO);
      chkI("t6_rDone", rDone - r0, 1);
      chkI("t6_err", errCnt - e0, 1);
      chkV("t6_dData", lastDData, '0);
      chkB("t6_idle", memReadReq, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
